// File: rtl/twiddle_multiplier.sv
// Complex sample x W16^sel twiddle multiplier for the pipelined FFT datapath.
// Three-stage pipeline: input capture, partial products, combine/round/saturate.
module twiddle_multiplier #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2:0]           sel,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 ovf_clr,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 ovf
);

  localparam int unsigned PW = DW + TW;
  localparam int unsigned FW = DW + TW + 1;

  localparam logic signed [FW-1:0] RND  = FW'(2 ** (TW - 2));
  localparam logic signed [FW-1:0] MAXV = FW'(2 ** (DW - 1) - 1);
  localparam logic signed [FW-1:0] MINV = ~MAXV;

  // Clamp a wide signed value into DW bits; MSB of the result flags saturation.
  function automatic logic [DW:0] sat(input logic signed [FW-1:0] x);
    if (x > MAXV) begin
      sat = {1'b1, MAXV[DW-1:0]};
    end else if (x < MINV) begin
      sat = {1'b1, MINV[DW-1:0]};
    end else begin
      sat = {1'b0, x[DW-1:0]};
    end
  endfunction

  // Stage 1 state
  logic                 s1_valid;
  logic [2:0]           s1_sel;
  logic signed [DW-1:0] s1_re;
  logic signed [DW-1:0] s1_im;

  // Stage 2 state
  logic                 s2_valid;
  logic [2:0]           s2_sel;
  logic signed [DW-1:0] s2_re;
  logic signed [DW-1:0] s2_im;
  logic signed [PW-1:0] p_ac;
  logic signed [PW-1:0] p_bd;
  logic signed [PW-1:0] p_ad;
  logic signed [PW-1:0] p_bc;

  // Twiddle coefficients for the stage-1 sample
  logic signed [TW-1:0] coef_re_c;
  logic signed [TW-1:0] coef_im_c;

  // Stage 3 combinational result
  logic signed [FW-1:0] re_full;
  logic signed [FW-1:0] im_full;
  logic signed [FW-1:0] re_shr;
  logic signed [FW-1:0] im_shr;
  logic signed [FW-1:0] neg_a;
  logic signed [DW-1:0] res_re_c;
  logic signed [DW-1:0] res_im_c;
  logic                 sat_re_c;
  logic                 sat_im_c;

  // Capture the incoming sample; data and sel only move on a valid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= 3'd0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel <= sel;
        s1_re  <= din_re;
        s1_im  <= din_im;
      end
    end
  end

  // Twiddle ROM, W16^k = c + j*d in Q1.15; k=0 and k=4 bypass the multipliers.
  always_comb begin
    coef_re_c = '0;
    coef_im_c = '0;
    case (s1_sel)
      3'd1: begin coef_re_c = TW'(30274);  coef_im_c = TW'(-12540); end
      3'd2: begin coef_re_c = TW'(23170);  coef_im_c = TW'(-23170); end
      3'd3: begin coef_re_c = TW'(12540);  coef_im_c = TW'(-30274); end
      3'd5: begin coef_re_c = TW'(-12540); coef_im_c = TW'(-30274); end
      3'd6: begin coef_re_c = TW'(-23170); coef_im_c = TW'(-23170); end
      3'd7: begin coef_re_c = TW'(-30274); coef_im_c = TW'(-12540); end
      default: begin coef_re_c = '0; coef_im_c = '0; end
    endcase
  end

  // Register the four partial products alongside the raw sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sel   <= 3'd0;
      s2_re    <= '0;
      s2_im    <= '0;
      p_ac     <= '0;
      p_bd     <= '0;
      p_ad     <= '0;
      p_bc     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sel   <= s1_sel;
      s2_re    <= s1_re;
      s2_im    <= s1_im;
      p_ac     <= PW'(s1_re) * PW'(coef_re_c);
      p_bd     <= PW'(s1_im) * PW'(coef_im_c);
      p_ad     <= PW'(s1_re) * PW'(coef_im_c);
      p_bc     <= PW'(s1_im) * PW'(coef_re_c);
    end
  end

  // Combine, round half-up, saturate; select bypass / -j special cases.
  always_comb begin
    re_full  = FW'(p_ac) - FW'(p_bd);
    im_full  = FW'(p_ad) + FW'(p_bc);
    re_shr   = (re_full + RND) >>> (TW - 1);
    im_shr   = (im_full + RND) >>> (TW - 1);
    neg_a    = -FW'(s2_re);
    res_re_c = '0;
    res_im_c = '0;
    sat_re_c = 1'b0;
    sat_im_c = 1'b0;
    case (s2_sel)
      3'd0: begin
        res_re_c = s2_re;
        res_im_c = s2_im;
      end
      3'd4: begin
        res_re_c             = s2_im;
        {sat_im_c, res_im_c} = sat(neg_a);
      end
      default: begin
        {sat_re_c, res_re_c} = sat(re_shr);
        {sat_im_c, res_im_c} = sat(im_shr);
      end
    endcase
  end

  // Output register; data holds across invalid slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= s2_valid;
      if (s2_valid) begin
        dout_re <= res_re_c;
        dout_im <= res_im_c;
      end
    end
  end

  // Sticky overflow; a valid saturating result wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (s2_valid && (sat_re_c || sat_im_c)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twiddle_multiplier.sv
// Scoreboard bench for twiddle_multiplier: driver pushes expected results,
// a negedge monitor pops and checks value and arrival cycle.
module tb_twiddle_multiplier;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [2:0]         sel;
  logic signed [15:0] din_re;
  logic signed [15:0] din_im;
  logic               ovf_clr;
  logic               dout_valid;
  logic signed [15:0] dout_re;
  logic signed [15:0] dout_im;
  logic               ovf;

  twiddle_multiplier #(.DW(16), .TW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sel        (sel),
    .din_re     (din_re),
    .din_im     (din_im),
    .ovf_clr    (ovf_clr),
    .dout_valid (dout_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Golden model of W16^k multiplication with round half-up and saturation.
  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic longint rnd15(input longint x);
    return (x + 16384) >>> 15;
  endfunction

  function automatic void model(input int k, input int a, input int b,
                                output int er, output int ei);
    int cr[8];
    int ci[8];
    cr = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    ci = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};
    if (k == 0) begin
      er = a; ei = b;
    end else if (k == 4) begin
      er = b; ei = sat16(-longint'(a));
    end else begin
      er = sat16(rnd15(longint'(a) * cr[k] - longint'(b) * ci[k]));
      ei = sat16(rnd15(longint'(a) * ci[k] + longint'(b) * cr[k]));
    end
  endfunction

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got (%0d,%0d) expected none (cycle %0d)",
                 dout_re, dout_im, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_re", int'(dout_re), e.re);
        check("out_im", int'(dout_im), e.im);
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one valid sample for one cycle; optionally record its expected result.
  task automatic send(input int k, input int a, input int b,
                      input int er, input int ei, input bit track);
    exp_t e;
    in_valid = 1'b1;
    sel      = 3'(k);
    din_re   = 16'(a);
    din_im   = 16'(b);
    if (track) begin
      e.re = er; e.im = ei; e.cyc = cyc + 3;
      q.push_back(e);
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int k, input int a, input int b);
    int er, ei;
    model(k, a, b, er, ei);
    send(k, a, b, er, ei, 1'b1);
  endtask

  initial begin
    int sa[8];
    int sb[8];
    sa = '{12000, 20000, -9000, 32767, -25000, 5000, -32768, 31000};
    sb = '{-7000, 15000, 30000, -32768, -25000, 12345, 100, 31000};
    rst = 1'b1; in_valid = 1'b0; sel = 3'd0; din_re = '0; din_im = '0; ovf_clr = 1'b0;

    // Reset held with in_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      din_re = 16'(1234); din_im = 16'(-77);
      check("rst_valid", int'(dout_valid), 0);
      check("rst_re", int'(dout_re), 0);
      check("rst_im", int'(dout_im), 0);
      check("rst_ovf", int'(ovf), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    step(2);

    // Bypass
    send(0, 1000, -2000, 1000, -2000, 1'b1);
    step(4);
    check("bypass_ovf", int'(ovf), 0);

    // Multiply with rounding
    send(2, 16384, 0, 11585, -11585, 1'b1);
    send(1, 0, 16384, 6270, 15137, 1'b1);
    step(4);

    // -j and its saturating corner
    send(4, 1000, -2000, -2000, -1000, 1'b1);
    check("negj_pre_ovf", int'(ovf), 0);
    send(4, -32768, 5, 5, 32767, 1'b1);
    step(3);
    check("negj_sat_ovf", int'(ovf), 1);

    // Sticky flag and clear
    step(3);
    check("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf), 0);

    // Multiply saturation
    send(6, -32768, -32768, 0, 32767, 1'b1);
    step(2);
    check("mul_sat_ovf", int'(ovf), 1);
    step(5);
    check("mul_sat_sticky", int'(ovf), 1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("mul_sat_cleared", int'(ovf), 0);

    // Clear coincident with a new saturating output: set wins
    send(4, -32768, 0, 0, 32767, 1'b1);
    step(1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("set_beats_clr", int'(ovf), 1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("clr_after", int'(ovf), 0);
    step(3);

    // Streaming, sel cycling 0..7, then valid pattern 1,0,1
    for (int i = 0; i < 8; i++) send_model(i, sa[i], sb[i]);
    send_model(3, -1234, 4321);
    step(1);
    send_model(5, 22222, -11111);
    step(6);

    // Mid-stream reset flushes two in-flight samples
    send(1, 1000, 1000, 0, 0, 1'b0);
    send(2, 2000, 2000, 0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(dout_valid), 0);
    check("midrst_re", int'(dout_re), 0);
    check("midrst_ovf", int'(ovf), 0);
    step(1);
    rst = 1'b0;
    step(6);
    check("post_rst_idle", int'(dout_valid), 0);

    // Recovery after reset
    send_model(7, 10000, -20000);
    step(6);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
